inst_queue: RTL and testbench

Parametrised multi-port instruction queue between the fetch stage and the dual-issue decode stage. Accepts up to FETCH_W instruction words per cycle from the instruction SRAM interface, tagged with PC and fetch-exception bits, and presents up to ISSUE_W oldest entries to the issue logic. It generalises the fixed two-in/two-out instruction FIFO:

- depth and port counts are configurable;
- there is an explicit write acknowledge;
- an occupancy count is exported;
- a branch flush can retain the delay-slot instruction.

---
 rtl/inst_queue.sv | 146 ++++++++++++++
 tb/tb_inst_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Multi-port instruction queue between fetch and dual-issue decode.
// Circular buffer with all-or-nothing writes, prefix pops and delay-slot-preserving flush.
module inst_queue #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DATA_W  = 32,
    parameter int EXP_W   = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_flush_keep_ds,
    input  logic [FETCH_W-1:0]         i_wr_en,
    input  logic [FETCH_W*DATA_W-1:0]  i_wr_data,
    input  logic [31:0]                i_wr_addr,
    input  logic [FETCH_W*EXP_W-1:0]   i_wr_exp,
    output logic                       o_wr_ack,
    input  logic [ISSUE_W-1:0]         i_rd_en,
    output logic [ISSUE_W*DATA_W-1:0]  o_rd_data,
    output logic [ISSUE_W*32-1:0]      o_rd_addr,
    output logic [ISSUE_W*EXP_W-1:0]   o_rd_exp,
    output logic [ISSUE_W-1:0]         o_rd_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_almost_empty,
    output logic                       o_full,
    output logic                       o_ds_missing
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FETCH_C = CW'(FETCH_W);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [31:0]       r_addr [DEPTH];
    logic [EXP_W-1:0]  r_exp  [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_ds_missing;

    logic [CW-1:0]     w_n_push;
    logic [CW-1:0]     w_n_pop;
    logic [CW-1:0]     w_free;
    logic              w_full;
    logic              w_wr_ack;
    logic              w_push_run;
    logic              w_pop_run;
    logic [ISSUE_W-1:0] w_rd_valid;
    logic [AW-1:0]     w_pop_ptr;

    // Push/pop counts are the lengths of the contiguous prefixes from slot 0.
    always_comb begin
        w_n_push   = '0;
        w_push_run = 1'b1;
        for (int k = 0; k < FETCH_W; k++) begin
            if (w_push_run && i_wr_en[k]) begin
                w_n_push = w_n_push + ONE_C;
            end else begin
                w_push_run = 1'b0;
            end
        end
        w_n_pop   = '0;
        w_pop_run = 1'b1;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_rd_valid[i] = (r_count > CW'(i));
            if (w_pop_run && i_rd_en[i] && w_rd_valid[i]) begin
                w_n_pop = w_n_pop + ONE_C;
            end else begin
                w_pop_run = 1'b0;
            end
        end
    end

    // Acceptance uses registered count only; full blocks even writes that would fit.
    assign w_free    = DEPTH_C - r_count;
    assign w_full    = (w_free < FETCH_C);
    assign w_wr_ack  = i_rst && !i_flush && !w_full && (w_n_push != '0) && (w_n_push <= w_free);
    assign w_pop_ptr = r_head + w_n_pop[AW-1:0];

    // Pointer, occupancy and delay-slot status update.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_ds_missing <= 1'b0;
        end else if (i_flush) begin
            if (i_flush_keep_ds && (r_count > w_n_pop)) begin
                r_head       <= w_pop_ptr;
                r_tail       <= w_pop_ptr + AW'(1);
                r_count      <= ONE_C;
                r_ds_missing <= 1'b0;
            end else begin
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                r_ds_missing <= i_flush_keep_ds;
            end
        end else begin
            r_head       <= w_pop_ptr;
            r_tail       <= w_wr_ack ? (r_tail + w_n_push[AW-1:0]) : r_tail;
            r_count      <= r_count - w_n_pop + (w_wr_ack ? w_n_push : '0);
            r_ds_missing <= 1'b0;
        end
    end

    // Entry storage; not reset, contents are only meaningful under rd_valid.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (w_wr_ack && (CW'(k) < w_n_push)) begin
                r_data[r_tail + AW'(k)] <= i_wr_data[k*DATA_W +: DATA_W];
                r_addr[r_tail + AW'(k)] <= i_wr_addr + 32'(4 * k);
                r_exp[r_tail + AW'(k)]  <= i_wr_exp[k*EXP_W +: EXP_W];
            end else begin
                r_data[r_tail + AW'(k)] <= r_data[r_tail + AW'(k)];
                r_addr[r_tail + AW'(k)] <= r_addr[r_tail + AW'(k)];
                r_exp[r_tail + AW'(k)]  <= r_exp[r_tail + AW'(k)];
            end
        end
    end

    // Oldest ISSUE_W entries presented from the head, wrapping through index 0.
    always_comb begin
        o_rd_data = '0;
        o_rd_addr = '0;
        o_rd_exp  = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            o_rd_data[i*DATA_W +: DATA_W] = r_data[r_head + AW'(i)];
            o_rd_addr[i*32 +: 32]         = r_addr[r_head + AW'(i)];
            o_rd_exp[i*EXP_W +: EXP_W]    = r_exp[r_head + AW'(i)];
        end
    end

    assign o_wr_ack       = w_wr_ack;
    assign o_rd_valid     = w_rd_valid;
    assign o_count        = r_count;
    assign o_empty        = (r_count == '0);
    assign o_almost_empty = (r_count == ONE_C);
    assign o_full         = w_full;
    assign o_ds_missing   = r_ds_missing;

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH=16, FETCH_W=2, ISSUE_W=2).
module tb_inst_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        flush_keep_ds;
    logic [1:0]  wr_en;
    logic [63:0] wr_data;
    logic [31:0] wr_addr;
    logic [23:0] wr_exp;
    logic        wr_ack;
    logic [1:0]  rd_en;
    logic [63:0] rd_data;
    logic [63:0] rd_addr;
    logic [23:0] rd_exp;
    logic [1:0]  rd_valid;
    logic [4:0]  count;
    logic        empty;
    logic        almost_empty;
    logic        full;
    logic        ds_missing;

    int n_vec = 0;
    int n_err = 0;

    inst_queue #(.DEPTH(16), .FETCH_W(2), .ISSUE_W(2), .DATA_W(32), .EXP_W(12)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_flush_keep_ds(flush_keep_ds),
        .i_wr_en(wr_en), .i_wr_data(wr_data), .i_wr_addr(wr_addr), .i_wr_exp(wr_exp),
        .o_wr_ack(wr_ack), .i_rd_en(rd_en), .o_rd_data(rd_data), .o_rd_addr(rd_addr),
        .o_rd_exp(rd_exp), .o_rd_valid(rd_valid), .o_count(count), .o_empty(empty),
        .o_almost_empty(almost_empty), .o_full(full), .o_ds_missing(ds_missing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs; ack is sampled before the edge, inputs idle afterwards.
    task automatic step(input logic [1:0] wen, input logic [31:0] addr, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [1:0] ren, input logic fl,
                        input logic keep, output logic ack);
        wr_en = wen; wr_addr = addr; wr_data = {d1, d0};
        wr_exp = {12'hE01, 12'hE00};
        rd_en = ren; flush = fl; flush_keep_ds = keep;
        #1;
        ack = wr_ack;
        @(posedge clk);
        #1;
        wr_en = 2'b00; rd_en = 2'b00; flush = 1'b0; flush_keep_ds = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        if (count !== 5'd0) begin $display("FAIL reset_count got %0d want 0", count); n_err++; end
        n_vec++;
        if ({empty, almost_empty, full} !== 3'b100) begin
            $display("FAIL reset_flags got %b want 100", {empty, almost_empty, full}); n_err++;
        end
        n_vec++;
        if ({rd_valid, ds_missing, wr_ack} !== 4'b0000) begin
            $display("FAIL reset_valid_ds_ack got %b want 0000", {rd_valid, ds_missing, wr_ack}); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_single_fetch();
        logic ack;
        step(2'b11, 32'hBFC0_0000, 32'h2408_0001, 32'h2409_0002, 2'b00, 1'b0, 1'b0, ack);
        if (ack !== 1'b1) begin $display("FAIL fetch_ack got %b want 1", ack); n_err++; end
        n_vec++;
        if ({count, rd_valid, empty} !== {5'd2, 2'b11, 1'b0}) begin
            $display("FAIL fetch_state got cnt=%0d v=%b e=%b want 2 11 0", count, rd_valid, empty); n_err++;
        end
        n_vec++;
        if (rd_addr !== 64'hBFC0_0004_BFC0_0000) begin
            $display("FAIL fetch_addr got %h want bfc00004bfc00000", rd_addr); n_err++;
        end
        n_vec++;
        if ({rd_data, rd_exp} !== {64'h2409_0002_2408_0001, 24'hE01E00}) begin
            $display("FAIL fetch_data got %h %h want 2409000224080001 e01e00", rd_data, rd_exp); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_fill();
        logic ack;
        logic all_ack;
        do_reset();
        all_ack = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step(2'b11, 32'h1000 + 32'(8 * j), 32'hD000_0000 + 32'(2 * j), 32'hD000_0001 + 32'(2 * j),
                 2'b00, 1'b0, 1'b0, ack);
            all_ack = all_ack & ack;
        end
        if (all_ack !== 1'b1) begin $display("FAIL fill_acks got %b want 1", all_ack); n_err++; end
        n_vec++;
        if ({count, full} !== {5'd16, 1'b1}) begin
            $display("FAIL fill_full got cnt=%0d full=%b want 16 1", count, full); n_err++;
        end
        n_vec++;
        step(2'b11, 32'h5000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        if ({ack, count} !== {1'b0, 5'd16}) begin
            $display("FAIL fill_ninth got ack=%b cnt=%0d want 0 16", ack, count); n_err++;
        end
        n_vec++;
        step(2'b00, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0, ack);
        if ({count, full, rd_addr[31:0]} !== {5'd15, 1'b1, 32'h1004}) begin
            $display("FAIL fill_pop1 got cnt=%0d full=%b a=%h want 15 1 1004", count, full, rd_addr[31:0]); n_err++;
        end
        n_vec++;
        step(2'b01, 32'h6000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        if ({ack, count} !== {1'b0, 5'd15}) begin
            $display("FAIL fill_single_at15 got ack=%b cnt=%0d want 0 15", ack, count); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_wrap();
        logic ack;
        do_reset();
        for (int j = 0; j < 7; j++) step(2'b11, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        for (int j = 0; j < 7; j++) step(2'b00, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, ack);
        for (int j = 0; j < 7; j++)
            step(2'b11, 32'h2000 + 32'(8 * j), 32'hA0 + 32'(j), 32'hB0 + 32'(j), 2'b00, 1'b0, 1'b0, ack);
        step(2'b01, 32'h2038, 32'hA7, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        if ({count, rd_addr} !== {5'd15, 64'h0000_2004_0000_2000}) begin
            $display("FAIL wrap_setup got cnt=%0d a=%h want 15 0000200400002000", count, rd_addr); n_err++;
        end
        n_vec++;
        step(2'b01, 32'h3000, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, ack);
        if (ack !== 1'b0) begin $display("FAIL wrap_push_ack got %b want 0", ack); n_err++; end
        n_vec++;
        if ({count, rd_addr, rd_data[31:0]} !== {5'd13, 64'h0000_200C_0000_2008, 32'hA1}) begin
            $display("FAIL wrap_head0 got cnt=%0d a=%h d=%h want 13 0000200c00002008 a1",
                     count, rd_addr, rd_data[31:0]); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_partial_pop();
        logic ack;
        do_reset();
        step(2'b01, 32'h40, 32'h1, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        if ({count, almost_empty, rd_valid} !== {5'd1, 1'b1, 2'b01}) begin
            $display("FAIL pp_one got cnt=%0d ae=%b v=%b want 1 1 01", count, almost_empty, rd_valid); n_err++;
        end
        n_vec++;
        step(2'b00, 32'h0, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, ack);
        if ({count, empty} !== {5'd0, 1'b1}) begin
            $display("FAIL pp_pop_over got cnt=%0d e=%b want 0 1", count, empty); n_err++;
        end
        n_vec++;
        step(2'b10, 32'h60, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        if ({ack, count} !== {1'b0, 5'd0}) begin
            $display("FAIL pp_gap_write got ack=%b cnt=%0d want 0 0", ack, count); n_err++;
        end
        n_vec++;
        step(2'b11, 32'h50, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        step(2'b01, 32'h58, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        step(2'b00, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, ack);
        if ({count, rd_addr[31:0]} !== {5'd3, 32'h50}) begin
            $display("FAIL pp_gap_pop got cnt=%0d a=%h want 3 50", count, rd_addr[31:0]); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_flush();
        logic ack;
        do_reset();
        step(2'b11, 32'h100, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        step(2'b11, 32'h108, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        step(2'b11, 32'h900, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, ack);
        if (ack !== 1'b0) begin $display("FAIL keep_ack got %b want 0", ack); n_err++; end
        n_vec++;
        if ({count, rd_valid, rd_addr[31:0], ds_missing} !== {5'd1, 2'b01, 32'h104, 1'b0}) begin
            $display("FAIL keep_ds got cnt=%0d v=%b a=%h dsm=%b want 1 01 104 0",
                     count, rd_valid, rd_addr[31:0], ds_missing); n_err++;
        end
        n_vec++;
        step(2'b00, 32'h0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, ack);
        if ({count, ds_missing} !== {5'd0, 1'b1}) begin
            $display("FAIL keep_missing got cnt=%0d dsm=%b want 0 1", count, ds_missing); n_err++;
        end
        n_vec++;
        step(2'b00, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        if (ds_missing !== 1'b0) begin $display("FAIL ds_pulse_len got %b want 0", ds_missing); n_err++; end
        n_vec++;
        step(2'b11, 32'h200, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        step(2'b11, 32'h208, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, ack);
        if ({ack, count, empty, ds_missing} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
            $display("FAIL plain_flush got ack=%b cnt=%0d e=%b dsm=%b want 0 0 1 0", ack, count, empty, ds_missing);
            n_err++;
        end
        n_vec++;
        step(2'b01, 32'h300, 32'h77, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        if ({count, rd_addr[31:0], rd_data[31:0]} !== {5'd1, 32'h300, 32'h77}) begin
            $display("FAIL post_flush_write got cnt=%0d a=%h d=%h want 1 300 77",
                     count, rd_addr[31:0], rd_data[31:0]); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_reset_mid();
        logic ack;
        do_reset();
        for (int j = 0; j < 3; j++) step(2'b11, 32'h400, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        step(2'b01, 32'h418, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, ack);
        if (count !== 5'd7) begin $display("FAIL mid_setup got %0d want 7", count); n_err++; end
        n_vec++;
        rst = 1'b0;
        step(2'b11, 32'h500, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, ack);
        rst = 1'b1;
        #1;
        if ({count, empty, ds_missing, rd_valid} !== {5'd0, 1'b1, 1'b0, 2'b00}) begin
            $display("FAIL mid_reset got cnt=%0d e=%b dsm=%b v=%b want 0 1 0 00", count, empty, ds_missing, rd_valid);
            n_err++;
        end
        n_vec++;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; flush_keep_ds = 1'b0;
        wr_en = 2'b00; wr_data = 64'h0; wr_addr = 32'h0; wr_exp = 24'h0; rd_en = 2'b00;
        test_reset();
        test_single_fetch();
        test_fill();
        test_wrap();
        test_partial_pop();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
